// File: rtl/reflex_sequencer.sv
// Reaction-time game sequencer: debounced ready/fire buttons, a random armed delay, and reaction timing in ticks.
// Optional best-time tracking is built when REFLEX_BEST_TIME_EN is defined.
//
// state   | meaning
// IDLE    | waiting for the first ready press
// ARMED   | counting the random delay; fire here is a false start
// LIT     | led on, reaction counter running
// DONE    | valid reaction latched in result
// FALSE   | fire pressed before the light came on
// TIMEOUT | no fire within TIMEOUT_TICKS
module reflex_sequencer #(
    parameter int DEBOUNCE_CYCLES = 50,
    parameter int TICK_DIV        = 10,
    parameter int DELAY_MIN       = 8,
    parameter int DELAY_STEP      = 4,
    parameter int TIMEOUT_TICKS   = 999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready_n,
    input  logic        fire_n,
    output logic        led,
    output logic [11:0] result,
    output logic        result_valid,
    output logic        false_start,
    output logic        timeout,
    output logic [2:0]  state
`ifdef REFLEX_BEST_TIME_EN
    ,
    output logic [11:0] best
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_LIT     = 3'd2,
        S_DONE    = 3'd3,
        S_FALSE   = 3'd4,
        S_TIMEOUT = 3'd5
    } state_t;

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_W = $clog2(TICK_DIV + 1);
    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0] DEB_FIRE = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(TICK_DIV - 1);
    localparam logic [11:0] DMIN_C = 12'(DELAY_MIN);
    localparam logic [11:0] STEP_C = 12'(DELAY_STEP);
    localparam logic [11:0] TO_C   = 12'(TIMEOUT_TICKS);

    logic rdy_s1_q, rdy_s2_q, fir_s1_q, fir_s2_q;
    logic [DEB_W-1:0] rdy_cnt_q, rdy_cnt_d, fir_cnt_q, fir_cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [11:0] delay_q, delay_d, dcnt_q, dcnt_d, react_q, react_d;
    logic [11:0] result_q, result_d;
    state_t state_q, state_d;
    logic led_q, led_d, valid_q, valid_d, false_q, false_d, tout_q, tout_d;
    logic rdy_btn, fir_btn, rdy_press, fir_press, tick;
`ifdef REFLEX_BEST_TIME_EN
    logic [11:0] best_q, best_d;
`endif

    always_comb begin
        rdy_btn   = ~rdy_s2_q;
        fir_btn   = ~fir_s2_q;
        rdy_cnt_d = rdy_btn ? ((rdy_cnt_q == DEB_MAX) ? rdy_cnt_q : rdy_cnt_q + 1'b1) : '0;
        fir_cnt_d = fir_btn ? ((fir_cnt_q == DEB_MAX) ? fir_cnt_q : fir_cnt_q + 1'b1) : '0;
        // The counter passes DEBOUNCE_CYCLES-1 only once per hold, so each pulse is single.
        rdy_press = rdy_btn && (rdy_cnt_q == DEB_FIRE);
        fir_press = fir_btn && (fir_cnt_q == DEB_FIRE);
        tick      = (div_q == DIV_MAX);
        div_d     = tick ? '0 : div_q + 1'b1;
        lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        state_d  = state_q;
        delay_d  = delay_q;
        dcnt_d   = dcnt_q;
        react_d  = react_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: if (rdy_press) state_d = S_ARMED;
            S_ARMED: begin
                if (fir_press)               state_d = S_FALSE;
                else if (dcnt_q == delay_q)  state_d = S_LIT;
                else if (tick)               dcnt_d  = dcnt_q + 12'd1;
            end
            S_LIT: begin
                // Fire wins over a coincident tick, so result is the pre-increment count.
                if (fir_press) begin
                    result_d = react_q;
                    state_d  = S_DONE;
                end else if (react_q == TO_C) begin
                    result_d = TO_C;
                    state_d  = S_TIMEOUT;
                end else if (tick) begin
                    react_d = react_q + 12'd1;
                end
            end
            S_DONE, S_FALSE, S_TIMEOUT: if (rdy_press) state_d = S_ARMED;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_ARMED && state_q != S_ARMED) begin
            div_d   = '0;
            dcnt_d  = '0;
            delay_d = DMIN_C + 12'(lfsr_q[2:0]) * STEP_C;
        end
        if (state_d == S_LIT && state_q != S_LIT) begin
            div_d   = '0;
            react_d = '0;
        end

        led_d   = (state_d == S_LIT);
        valid_d = (state_d == S_DONE);
        false_d = (state_d == S_FALSE);
        tout_d  = (state_d == S_TIMEOUT);
`ifdef REFLEX_BEST_TIME_EN
        best_d = best_q;
        if (state_d == S_DONE && state_q != S_DONE && result_d < best_q) best_d = result_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdy_s1_q  <= 1'b1;
            rdy_s2_q  <= 1'b1;
            fir_s1_q  <= 1'b1;
            fir_s2_q  <= 1'b1;
            rdy_cnt_q <= '0;
            fir_cnt_q <= '0;
            div_q     <= '0;
            lfsr_q    <= 8'hA5;
            delay_q   <= '0;
            dcnt_q    <= '0;
            react_q   <= '0;
            result_q  <= '0;
            state_q   <= S_IDLE;
            led_q     <= 1'b0;
            valid_q   <= 1'b0;
            false_q   <= 1'b0;
            tout_q    <= 1'b0;
`ifdef REFLEX_BEST_TIME_EN
            best_q    <= 12'hFFF;
`endif
        end else begin
            rdy_s1_q  <= ready_n;
            rdy_s2_q  <= rdy_s1_q;
            fir_s1_q  <= fire_n;
            fir_s2_q  <= fir_s1_q;
            rdy_cnt_q <= rdy_cnt_d;
            fir_cnt_q <= fir_cnt_d;
            div_q     <= div_d;
            lfsr_q    <= lfsr_d;
            delay_q   <= delay_d;
            dcnt_q    <= dcnt_d;
            react_q   <= react_d;
            result_q  <= result_d;
            state_q   <= state_d;
            led_q     <= led_d;
            valid_q   <= valid_d;
            false_q   <= false_d;
            tout_q    <= tout_d;
`ifdef REFLEX_BEST_TIME_EN
            best_q    <= best_d;
`endif
        end
    end

    assign led          = led_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign false_start  = false_q;
    assign timeout      = tout_q;
    assign state        = state_q;
`ifdef REFLEX_BEST_TIME_EN
    assign best         = best_q;
`endif

endmodule
